// File: rtl/midi_merge_arbiter.sv
// rtl/midi_merge_arbiter.sv - round-robin serial arbiter sharing the merged MIDI output among four inputs
// Optional drop counters are built when MIDI_MERGE_DROP_CNT_EN is defined.
module midi_merge_arbiter #(
  parameter int CLKS_PER_BIT = 32,
  parameter int IDLE_BITS    = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  midi_in,
  input  logic [3:0]  in_en,
  output logic [3:0]  midi_out,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [3:0]  drop_pulse,
  output logic [31:0] drop_cnt
);

  localparam int IDLE_CLKS = IDLE_BITS * CLKS_PER_BIT;
  localparam int CW = (IDLE_CLKS > 1) ? $clog2(IDLE_CLKS) : 1;
  localparam logic [CW-1:0] TERM = CW'(IDLE_CLKS - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state;
  logic [3:0]    s1, s, s_d;
  logic [3:0]    fall, cand, pend;
  logic [1:0]    gidx, rr_ptr, win, idx;
  logic          found, sg;
  logic [CW-1:0] cnt;

  assign fall = s_d & ~s;
  assign cand = (fall | pend) & in_en;
  assign sg   = s[gidx];

  // Scan downwards so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    idx   = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 4'hF;
      s          <= 4'hF;
      s_d        <= 4'hF;
      state      <= IDLE;
      grant      <= 4'h0;
      busy       <= 1'b0;
      gidx       <= 2'd0;
      rr_ptr     <= 2'd0;
      cnt        <= '0;
      midi_out   <= 4'hF;
      drop_pulse <= 4'h0;
      pend       <= 4'h0;
    end else begin
      s1         <= midi_in;
      s          <= s1;
      s_d        <= s;
      drop_pulse <= 4'h0;
      pend       <= 4'h0;
      case (state)
        IDLE: begin
          midi_out <= 4'hF;
          if (found) begin
            state      <= ACTIVE;
            gidx       <= win;
            grant      <= 4'b0001 << win;
            busy       <= 1'b1;
            cnt        <= '0;
            midi_out   <= {4{s[win]}};
            drop_pulse <= cand & ~(4'b0001 << win);
          end
        end
        default: begin
          if (!in_en[gidx] || (sg && cnt == TERM)) begin
            state    <= IDLE;
            grant    <= 4'h0;
            busy     <= 1'b0;
            rr_ptr   <= gidx + 2'd1;
            midi_out <= 4'hF;
            cnt      <= '0;
            // A start bit coinciding with release is held for arbitration next cycle.
            pend     <= fall & in_en;
          end else begin
            midi_out   <= {4{sg}};
            drop_pulse <= fall & in_en & ~grant;
            if (!sg)
              cnt <= '0;
            else if (cnt != TERM)
              cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

`ifdef MIDI_MERGE_DROP_CNT_EN
  logic [7:0] dcnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dcnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (drop_pulse[i] && dcnt[i] != 8'hFF) dcnt[i] <= dcnt[i] + 8'd1;
    end
  end

  assign drop_cnt = {dcnt[3], dcnt[2], dcnt[1], dcnt[0]};
`else
  assign drop_cnt = 32'd0;
`endif

endmodule
